seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_pattern_tx.sv | 121 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and preamble length for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int PRE_LEN = 2;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word in IDLE, shifts it out MSB first, then idles GAP_LEN cycles.
// Optional preamble of PRE_LEN ones before the data, enabled by defining SEQ_TX_PREAMBLE_EN.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int GAP_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serout,
    output logic             ser_valid,
    output logic             done,
    output logic [1:0]       ps
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [3:0]       gap_cnt;
    logic             accept;

`ifdef SEQ_TX_PREAMBLE_EN
    localparam int PW = $clog2(PRE_LEN);
    logic [PW-1:0] pre_cnt;
`endif

    assign load_ready = (state == IDLE);
    assign accept     = load_valid && load_ready;
    assign done       = (state == GAP) && (gap_cnt == 4'd0);
    assign ps         = state;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_TX_PREAMBLE_EN
                    nxt = PRE;
`else
                    nxt = SHIFT;
`endif
                end
            end
            PRE: begin
`ifdef SEQ_TX_PREAMBLE_EN
                if (pre_cnt == '0) nxt = SHIFT;
`else
                nxt = IDLE;
`endif
            end
            SHIFT: if (cnt == '0) nxt = GAP;
            GAP:   if (gap_cnt == 4'd0) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // serout is registered, so each branch loads the bit shown in the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            serout    <= 1'b0;
            ser_valid <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
            pre_cnt   <= '0;
`endif
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= CW'(WIDTH - 1);
                        ser_valid <= 1'b1;
`ifdef SEQ_TX_PREAMBLE_EN
                        shreg     <= load_data;
                        serout    <= 1'b1;
                        pre_cnt   <= PW'(PRE_LEN - 1);
`else
                        shreg     <= {load_data[WIDTH-2:0], 1'b0};
                        serout    <= load_data[WIDTH-1];
`endif
                    end
                end
                PRE: begin
`ifdef SEQ_TX_PREAMBLE_EN
                    if (pre_cnt == '0) begin
                        serout <= shreg[WIDTH-1];
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        pre_cnt <= pre_cnt - 1'b1;
                    end
`endif
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        serout    <= 1'b0;
                        ser_valid <= 1'b0;
                        gap_cnt   <= 4'(GAP_LEN - 1);
                    end else begin
                        serout <= shreg[WIDTH-1];
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        cnt    <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random stimulus against a per-cycle expected-stream model.
module tb_seq_pattern_tx;

    localparam int W  = 8;
    localparam int GL = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, serout, ser_valid, done;
    logic [1:0] ps;

    logic       lv2 = 1'b0;
    logic [1:0] ld2 = '0;
    logic       rdy2, so2, sv2, dn2;
    logic [1:0] ps2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(W), .GAP_LEN(GL)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .serout(serout), .ser_valid(ser_valid),
        .done(done), .ps(ps)
    );

    seq_pattern_tx #(.WIDTH(2), .GAP_LEN(3)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2),
        .load_ready(rdy2), .serout(so2), .ser_valid(sv2),
        .done(dn2), .ps(ps2)
    );

    typedef struct packed {
        logic       so;
        logic       sv;
        logic       dn;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    // Expected cycles following an acceptance: optional preamble, data MSB first, then the gap.
    task automatic push_word(input logic [7:0] d);
`ifdef SEQ_TX_PREAMBLE_EN
        for (int i = 0; i < 2; i++) q.push_back('{so: 1'b1, sv: 1'b1, dn: 1'b0, st: 2'd1});
`endif
        for (int i = W - 1; i >= 0; i--) q.push_back('{so: d[i], sv: 1'b1, dn: 1'b0, st: 2'd2});
        for (int i = 0; i < GL; i++) q.push_back('{so: 1'b0, sv: 1'b0, dn: (i == GL - 1), st: 2'd3});
    endtask

    // One cycle: check the current cycle against the model, then drive inputs for it.
    task automatic step(input logic lv, input logic [7:0] d, input logic r);
        exp_t e;
        logic idle;
        @(negedge clk);
        idle = (q.size() == 0);
        e = idle ? exp_t'(5'b0) : q.pop_front();
        chk("serout", 32'(serout), 32'(e.so));
        chk("ser_valid", 32'(ser_valid), 32'(e.sv));
        chk("done", 32'(done), 32'(e.dn));
        chk("ps", 32'(ps), 32'(e.st));
        chk("load_ready", 32'(load_ready), 32'(idle));
        load_valid = lv;
        load_data  = d;
        rst        = r;
        if (r) q.delete();
        else if (lv && idle) push_word(d);
    endtask

    initial begin
        // reset with load_valid asserted: nothing may be accepted
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // single word A5, with a 3C pulse during SHIFT that must be ignored
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

        // load_valid held high: FF then 00 back to back
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0);

        // reset on the 4th data cycle aborts the word, no done, no resume
        step(1'b1, 8'hA5, 1'b0);
`ifdef SEQ_TX_PREAMBLE_EN
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
`else
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
`endif
        step(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 49) == 0));
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // narrow word, long gap on the second instance
        begin
`ifdef SEQ_TX_PREAMBLE_EN
            localparam int N2 = 8;
            logic [N2-1:0] eso = 8'b11110000;
            logic [N2-1:0] esv = 8'b11110000;
            logic [N2-1:0] edn = 8'b00000010;
`else
            localparam int N2 = 6;
            logic [N2-1:0] eso = 6'b110000;
            logic [N2-1:0] esv = 6'b110000;
            logic [N2-1:0] edn = 6'b000010;
`endif
            @(negedge clk);
            chk("dut2_ready_idle", 32'(rdy2), 32'd1);
            lv2 = 1'b1;
            ld2 = 2'b11;
            for (int i = N2 - 1; i >= 0; i--) begin
                @(negedge clk);
                lv2 = 1'b0;
                chk("dut2_serout", 32'(so2), 32'(eso[i]));
                chk("dut2_ser_valid", 32'(sv2), 32'(esv[i]));
                chk("dut2_done", 32'(dn2), 32'(edn[i]));
                chk("dut2_ready", 32'(rdy2), 32'(i == 0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
